// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM encoding, compare opcode and instruction field positions
// for operand_issue.
package alu_pkg;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_ISSUE, S_WB} state_t;
  localparam logic [3:0] OP_CMP = 4'b1000;
  localparam int COND_HI = 31;
  localparam int COND_LO = 28;
  localparam int OP_HI = 27;
  localparam int OP_LO = 24;
  localparam int S_BIT = 23;
  localparam int IMM_HI = 18;
  localparam int IMM_LO = 3;
  localparam int SH_HI = 2;
  localparam int SH_LO = 0;
  function automatic logic [3:0] op_of(input logic [31:0] instr);
    return instr[OP_HI:OP_LO];
  endfunction
endpackage

// File: rtl/reg_file_16x32.sv
// reg_file_16x32: 16x32 register file, two async read ports, one sync write
// port, async clear.
module reg_file_16x32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [3:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_raddr_a,
  input  logic [3:0]  i_raddr_b,
  output logic [31:0] o_rdata_a,
  output logic [31:0] o_rdata_b
);
  logic [31:0] r_mem [16];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end
  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];
endmodule

// File: rtl/operand_issue.sv
// operand_issue: four-state operand read / ALU issue / writeback sequencer.
// Define OPERAND_ISSUE_CNT_EN to add the issue_cnt output and its counter.
module operand_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [3:0]  in_rn,
  input  logic [3:0]  in_rm,
  input  logic [3:0]  in_rd,
  output logic [31:0] alu_r1,
  output logic [31:0] alu_r2,
  output logic [31:0] alu_instr,
  input  logic        alu_cond_pass,
  input  logic [32:0] alu_out,
  input  logic [3:0]  alu_flg,
  output logic [3:0]  flags,
`ifdef OPERAND_ISSUE_CNT_EN
  output logic [15:0] issue_cnt,
`endif
  output logic        busy
);
  state_t r_state;
  state_t w_next;
  logic [31:0] r_instr;
  logic [3:0] r_rn;
  logic [3:0] r_rm;
  logic [3:0] r_rd;
  logic r_pass;
  logic w_accept;
  logic w_wb;
  logic w_is_cmp;
  logic [31:0] w_rd_a;
  logic [31:0] w_rd_b;
  logic w_unused;
  assign in_ready = (r_state == S_IDLE) && !rst;
  assign busy = r_state != S_IDLE;
  assign w_accept = in_valid && in_ready;
  assign w_is_cmp = op_of(r_instr) == OP_CMP;
  assign w_wb = (r_state == S_WB) && r_pass;
  assign w_unused = alu_out[32];
  always_comb begin
    w_next = r_state;
    w_next = (r_state == S_IDLE)  ? (w_accept ? S_READ : S_IDLE) :
             (r_state == S_READ)  ? S_ISSUE :
             (r_state == S_ISSUE) ? S_WB : S_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_instr <= '0;
      r_rn <= '0;
      r_rm <= '0;
      r_rd <= '0;
      r_pass <= 1'b0;
      alu_r1 <= '0;
      alu_r2 <= '0;
      alu_instr <= '0;
      flags <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_instr <= in_instr;
        r_rn <= in_rn;
        r_rm <= in_rm;
        r_rd <= in_rd;
      end
      if (r_state == S_READ) begin
        alu_r1 <= w_rd_a;
        alu_r2 <= w_rd_b;
        alu_instr <= r_instr;
      end
      if (r_state == S_ISSUE) r_pass <= alu_cond_pass;
      if (w_wb && (r_instr[S_BIT] || w_is_cmp)) flags <= alu_flg;
    end
  end
`ifdef OPERAND_ISSUE_CNT_EN
  logic [15:0] r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (w_wb) r_cnt <= r_cnt + 16'd1;
  end
  assign issue_cnt = r_cnt;
`endif
  // Writeback lands before the next READ, so dependent reads need no bypass.
  reg_file_16x32 u_rf (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_wb && !w_is_cmp),
    .i_waddr  (r_rd),
    .i_wdata  (alu_out[31:0]),
    .i_raddr_a(r_rn),
    .i_raddr_b(r_rm),
    .o_rdata_a(w_rd_a),
    .o_rdata_b(w_rd_b)
  );
endmodule

// File: tb/tb_operand_issue.sv
// tb_operand_issue: directed scoreboard bench for operand_issue with a small
// behavioural ALU; define OPERAND_ISSUE_CNT_EN to also check issue_cnt.
module tb_operand_issue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [31:0] in_instr = '0;
  logic [3:0] in_rn = '0;
  logic [3:0] in_rm = '0;
  logic [3:0] in_rd = '0;
  logic [31:0] alu_r1;
  logic [31:0] alu_r2;
  logic [31:0] alu_instr;
  logic alu_cond_pass;
  logic [32:0] alu_out;
  logic [3:0] alu_flg;
  logic [3:0] flags;
  logic busy;
`ifdef OPERAND_ISSUE_CNT_EN
  logic [15:0] issue_cnt;
`endif
  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  typedef struct {
    logic [3:0] cond;
    logic [3:0] op;
    logic s;
    logic [15:0] imm;
    logic [3:0] rn;
    logic [3:0] rm;
    logic [3:0] rd;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [3:0] fl;
  } vec_t;
  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] instr;
    logic [3:0] fl;
  } exp_t;
  exp_t q[$];
  vec_t v[10];

  operand_issue dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_rn        (in_rn),
    .in_rm        (in_rm),
    .in_rd        (in_rd),
    .alu_r1       (alu_r1),
    .alu_r2       (alu_r2),
    .alu_instr    (alu_instr),
    .alu_cond_pass(alu_cond_pass),
    .alu_out      (alu_out),
    .alu_flg      (alu_flg),
    .flags        (flags),
`ifdef OPERAND_ISSUE_CNT_EN
    .issue_cnt    (issue_cnt),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // ALU stand-in: cond E passes, cond 0 fails; ADD, CMP (subtract) and MOV imm.
  always_comb begin
    alu_cond_pass = alu_instr[31:28] == 4'hE;
    alu_out = '0;
    alu_flg = '0;
    if (alu_instr[27:24] == 4'h4) begin
      alu_out = {1'b0, alu_r1} + {1'b0, alu_r2};
      alu_flg = {alu_out[31], alu_out[31:0] == 32'd0, alu_out[32], 1'b0};
    end else if (alu_instr[27:24] == 4'h8) begin
      alu_out = {1'b0, alu_r1} - {1'b0, alu_r2};
      alu_flg = {alu_out[31], alu_out[31:0] == 32'd0, 2'b00};
    end else if (alu_instr[27:24] == 4'hD) begin
      alu_out = {17'd0, alu_instr[18:3]};
      alu_flg = {1'b0, alu_instr[18:3] == 16'd0, 2'b00};
    end
  end

  function automatic logic [31:0] mk(input logic [3:0] cond, input logic [3:0] op,
                                     input logic s, input logic [15:0] imm);
    return {cond, op, s, 4'b0000, imm, 3'b101};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_accept();
    int t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    longint last_t = -1;
    @(negedge clk);
    #1;
    forever begin
      if (!mon_en) last_t = -1;
      if (mon_en && in_valid && in_ready) begin
        if (last_t >= 0) chk("accept_gap", 32'($time - last_t), 32'd40);
        last_t = $time;
        if (q.size() == 0) begin
          chk("sb_empty", 32'd0, 32'd1);
          e = '{32'd0, 32'd0, 32'd0, 4'd0};
        end else e = q.pop_front();
        repeat (2) begin @(negedge clk); #1; end
        chk("alu_r1", alu_r1, e.r1);
        chk("alu_r2", alu_r2, e.r2);
        chk("alu_instr", alu_instr, e.instr);
        chk("busy_issue", 32'(busy), 32'd1);
        repeat (2) begin @(negedge clk); #1; end
        chk("flags", 32'(flags), 32'(e.fl));
        chk("in_ready_after_wb", 32'(in_ready), 32'd1);
      end else begin
        @(negedge clk);
        #1;
      end
    end
  end

  initial begin : driver
    v[0] = '{4'hE, 4'hD, 1'b0, 16'd5,  4'd0, 4'd0, 4'd1, 32'd0,  32'd0,  4'h0};
    v[1] = '{4'hE, 4'hD, 1'b0, 16'd7,  4'd0, 4'd0, 4'd2, 32'd0,  32'd0,  4'h0};
    v[2] = '{4'hE, 4'h4, 1'b0, 16'd0,  4'd1, 4'd2, 4'd3, 32'd5,  32'd7,  4'h0};
    v[3] = '{4'hE, 4'h4, 1'b0, 16'd0,  4'd3, 4'd3, 4'd4, 32'd12, 32'd12, 4'h0};
    v[4] = '{4'hE, 4'h8, 1'b0, 16'd0,  4'd3, 4'd3, 4'd1, 32'd12, 32'd12, 4'h4};
    v[5] = '{4'hE, 4'h4, 1'b0, 16'd0,  4'd1, 4'd2, 4'd6, 32'd5,  32'd7,  4'h4};
    v[6] = '{4'h0, 4'hD, 1'b1, 16'd99, 4'd0, 4'd0, 4'd2, 32'd0,  32'd0,  4'h4};
    v[7] = '{4'hE, 4'h4, 1'b1, 16'd0,  4'd2, 4'd4, 4'd7, 32'd7,  32'd24, 4'h0};
    v[8] = '{4'hE, 4'h4, 1'b0, 16'd0,  4'd6, 4'd7, 4'd8, 32'd12, 32'd31, 4'h0};
    v[9] = '{4'hE, 4'h4, 1'b0, 16'd0,  4'd8, 4'd1, 4'd9, 32'd43, 32'd5,  4'h0};
    repeat (2) @(negedge clk);
    chk("in_ready_in_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_r1", alu_r1, 32'd0);
    chk("rst_alu_r2", alu_r2, 32'd0);
    chk("rst_alu_instr", alu_instr, 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    @(negedge clk);
    mon_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_instr = mk(v[k].cond, v[k].op, v[k].s, v[k].imm);
      in_rn = v[k].rn;
      in_rm = v[k].rm;
      in_rd = v[k].rd;
      in_valid = 1'b1;
      q.push_back('{v[k].r1, v[k].r2, in_instr, v[k].fl});
      wait_accept();
    end
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("sb_drained", 32'(q.size()), 32'd0);
`ifdef OPERAND_ISSUE_CNT_EN
    chk("issue_cnt_burst", 32'(issue_cnt), 32'd9);
`endif
    mon_en = 1'b0;
    in_instr = mk(4'hE, 4'hD, 1'b1, 16'd77);
    in_rn = 4'd3;
    in_rm = 4'd0;
    in_rd = 4'd10;
    in_valid = 1'b1;
    wait_accept();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_alu_r1", alu_r1, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst_in_ready", 32'(in_ready), 32'd1);
    chk("postrst_flags", 32'(flags), 32'd0);
    chk("postrst_alu_instr", alu_instr, 32'd0);
`ifdef OPERAND_ISSUE_CNT_EN
    chk("postrst_issue_cnt", 32'(issue_cnt), 32'd0);
`endif
    @(negedge clk);
    mon_en = 1'b1;
    in_instr = mk(4'hE, 4'h4, 1'b0, 16'd0);
    in_rn = 4'd10;
    in_rm = 4'd9;
    in_rd = 4'd11;
    in_valid = 1'b1;
    q.push_back('{32'd0, 32'd0, in_instr, 4'h0});
    wait_accept();
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("sb_drained_end", 32'(q.size()), 32'd0);
`ifdef OPERAND_ISSUE_CNT_EN
    chk("issue_cnt_end", 32'(issue_cnt), 32'd1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
